// File: rtl/voice_allocator.sv
// voice_allocator
//   Buffers note requests from the song reader in a small FIFO and hands each
//   one to a free note player, scanning round-robin from the voice after the
//   last one loaded. Tracks which voices are sounding and reports the active
//   count plus the mixer attenuation shift.
//
// Optional feature: define VOICE_STEAL_EN to let a full FIFO with no free voice
//   reload voice rr_ptr instead of stalling the song reader.
//
// Ports
//   i_clk, i_reset_n         clock, asynchronous active-low reset
//   i_play                   1 = dispatch enabled; FIFO accepts regardless
//   i_req_valid/o_req_ready  request handshake; i_req_note, i_req_duration payload
//   i_voice_done             done_with_note from each player (bit i = voice i)
//   o_load_voice             one-hot single-cycle load strobe
//   o_load_note/_duration    payload for the strobed voice
//   o_busy_mask              voices currently allocated
//   o_active_count           popcount of o_busy_mask
//   o_mix_shift              0 (<=1 active), 1 (2 active), 2 (>=3 active)
//   o_fifo_level             occupied FIFO entries
module voice_allocator #(
  parameter int unsigned NUM_VOICES = 3,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                              i_clk,
  input  logic                              i_reset_n,
  input  logic                              i_play,
  input  logic                              i_req_valid,
  input  logic [5:0]                        i_req_note,
  input  logic [5:0]                        i_req_duration,
  output logic                              o_req_ready,
  input  logic [NUM_VOICES-1:0]             i_voice_done,
  output logic [NUM_VOICES-1:0]             o_load_voice,
  output logic [5:0]                        o_load_note,
  output logic [5:0]                        o_load_duration,
  output logic [NUM_VOICES-1:0]             o_busy_mask,
  output logic [$clog2(NUM_VOICES+1)-1:0]   o_active_count,
  output logic [1:0]                        o_mix_shift,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   o_fifo_level
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned LvlW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned RrW  = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int unsigned CntW = $clog2(NUM_VOICES + 1);

  // State
  logic [11:0]           r_mem [FIFO_DEPTH];
  logic [PtrW-1:0]       r_wr_ptr;
  logic [PtrW-1:0]       r_rd_ptr;
  logic [LvlW-1:0]       r_level;
  logic [RrW-1:0]        r_rr_ptr;
  logic [NUM_VOICES-1:0] r_busy_mask;
  logic [NUM_VOICES-1:0] r_voice_done_q;
  logic [NUM_VOICES-1:0] r_load_voice;
  logic [5:0]            r_load_note;
  logic [5:0]            r_load_duration;
  logic [CntW-1:0]       r_active_count;
  logic [1:0]            r_mix_shift;

  // Combinational
  logic                  w_full;
  logic                  w_empty;
  logic [NUM_VOICES-1:0] w_free;
  logic                  w_sel_found;
  logic [RrW-1:0]        w_sel_idx;
  logic [RrW-1:0]        w_cand;
  logic                  w_dispatch;
  logic                  w_steal;
  logic                  w_pop;
  logic                  w_push;
  logic [RrW-1:0]        w_target;
  logic [RrW-1:0]        w_rr_next;
  logic [NUM_VOICES-1:0] w_load_onehot;
  logic [NUM_VOICES-1:0] w_done_rise;
  logic [NUM_VOICES-1:0] w_busy_d;
  logic [CntW-1:0]       w_count_d;
  logic [1:0]            w_shift_d;
  logic [LvlW-1:0]       w_level_d;
  logic [11:0]           w_head;

  assign w_full  = (r_level == LvlW'(FIFO_DEPTH));
  assign w_empty = (r_level == '0);
  assign w_free  = ~r_busy_mask;
  assign w_head  = r_mem[r_rd_ptr];

  // First free voice scanning rr_ptr, rr_ptr+1, ... modulo NUM_VOICES.
  always_comb begin
    w_sel_found = 1'b0;
    w_sel_idx   = r_rr_ptr;
    w_cand      = r_rr_ptr;
    for (int unsigned k = 0; k < NUM_VOICES; k++) begin
      w_cand = RrW'((32'(r_rr_ptr) + k) % NUM_VOICES);
      if (!w_sel_found && w_free[w_cand]) begin
        w_sel_found = 1'b1;
        w_sel_idx   = w_cand;
      end
    end
  end

  assign w_dispatch = i_play & ~w_empty & w_sel_found;

`ifdef VOICE_STEAL_EN
  // Full FIFO, nothing free: reload the oldest round-robin slot rather than stall.
  assign w_steal = i_play & w_full & ~w_sel_found;
`else
  assign w_steal = 1'b0;
`endif

  assign w_pop       = w_dispatch | w_steal;
  assign w_target    = w_dispatch ? w_sel_idx : r_rr_ptr;
  assign w_rr_next   = RrW'((32'(w_target) + 32'd1) % NUM_VOICES);
  assign o_req_ready = ~w_full | w_pop;
  assign w_push      = i_req_valid & o_req_ready;

  always_comb begin
    w_load_onehot = '0;
    for (int unsigned i = 0; i < NUM_VOICES; i++) begin
      w_load_onehot[i] = w_pop && (w_target == RrW'(i));
    end
  end

  // Only a rising done edge frees a voice: a player's done flag may still be
  // high from its previous note for a cycle or two after a new load.
  assign w_done_rise = i_voice_done & ~r_voice_done_q;
  assign w_busy_d    = (r_busy_mask & ~w_done_rise) | w_load_onehot;

  always_comb begin
    w_count_d = '0;
    for (int unsigned i = 0; i < NUM_VOICES; i++) begin
      w_count_d = w_count_d + CntW'(w_busy_d[i]);
    end
    if (w_count_d <= CntW'(1)) begin
      w_shift_d = 2'd0;
    end else if (w_count_d == CntW'(2)) begin
      w_shift_d = 2'd1;
    end else begin
      w_shift_d = 2'd2;
    end
  end

  always_comb begin
    w_level_d = r_level;
    if (w_push && !w_pop) begin
      w_level_d = r_level + LvlW'(1);
    end else if (w_pop && !w_push) begin
      w_level_d = r_level - LvlW'(1);
    end
  end

  // Storage carries no reset; occupancy is governed by the pointers and level.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {i_req_note, i_req_duration};
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_wr_ptr        <= '0;
      r_rd_ptr        <= '0;
      r_level         <= '0;
      r_rr_ptr        <= '0;
      r_busy_mask     <= '0;
      r_voice_done_q  <= '0;
      r_load_voice    <= '0;
      r_load_note     <= '0;
      r_load_duration <= '0;
      r_active_count  <= '0;
      r_mix_shift     <= '0;
    end else begin
      r_level        <= w_level_d;
      r_busy_mask    <= w_busy_d;
      r_voice_done_q <= i_voice_done;
      r_load_voice   <= w_load_onehot;
      r_active_count <= w_count_d;
      r_mix_shift    <= w_shift_d;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PtrW'(1);
      end
      if (w_pop) begin
        r_rd_ptr        <= r_rd_ptr + PtrW'(1);
        r_rr_ptr        <= w_rr_next;
        r_load_note     <= w_head[11:6];
        r_load_duration <= w_head[5:0];
      end
    end
  end

  assign o_load_voice    = r_load_voice;
  assign o_load_note     = r_load_note;
  assign o_load_duration = r_load_duration;
  assign o_busy_mask     = r_busy_mask;
  assign o_active_count  = r_active_count;
  assign o_mix_shift     = r_mix_shift;
  assign o_fifo_level    = r_level;

endmodule

// File: tb/tb_voice_allocator.sv
// tb_voice_allocator
//   Bench for voice_allocator (NUM_VOICES=3, FIFO_DEPTH=4). A reference model
//   built on a request queue and a busy vector predicts every load strobe and
//   pushes it, stamped with its cycle, into an expectation queue; a separate
//   monitor pops and compares whenever the DUT strobes load_voice. The model
//   also checks the registered state outputs and req_ready every cycle.
//   Honours VOICE_STEAL_EN the same way the design does.
module tb_voice_allocator;
  localparam int NV    = 3;
  localparam int DEPTH = 4;

  typedef struct {
    int note;
    int dur;
  } req_t;

  typedef struct {
    int voice;
    int note;
    int dur;
    int cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          play;
  logic          req_valid;
  logic [5:0]    req_note;
  logic [5:0]    req_duration;
  logic          req_ready;
  logic [NV-1:0] voice_done;
  logic [NV-1:0] man_done;
  logic [NV-1:0] auto_done;
  logic          auto_mode;
  logic [NV-1:0] load_voice;
  logic [5:0]    load_note;
  logic [5:0]    load_duration;
  logic [NV-1:0] busy_mask;
  logic [1:0]    active_count;
  logic [1:0]    mix_shift;
  logic [2:0]    fifo_level;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  assign voice_done = auto_mode ? auto_done : man_done;

  voice_allocator #(
    .NUM_VOICES (NV),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .i_clk           (clk),
    .i_reset_n       (reset_n),
    .i_play          (play),
    .i_req_valid     (req_valid),
    .i_req_note      (req_note),
    .i_req_duration  (req_duration),
    .o_req_ready     (req_ready),
    .i_voice_done    (voice_done),
    .o_load_voice    (load_voice),
    .o_load_note     (load_note),
    .o_load_duration (load_duration),
    .o_busy_mask     (busy_mask),
    .o_active_count  (active_count),
    .o_mix_shift     (mix_shift),
    .o_fifo_level    (fifo_level)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, want, cyc);
    end
  endfunction

  function automatic int shift_of(input int n);
    return (n <= 1) ? 0 : (n == 2) ? 1 : 2;
  endfunction

  // ---------------------------------------------------------------- model
  req_t          m_q[$];
  exp_t          exp_q[$];
  logic [NV-1:0] m_busy;
  logic [NV-1:0] m_prev;
  int            m_rr;
  bit            m_pop;
  bit            m_ready;
  int            m_tgt;
  req_t          m_item;
  req_t          m_new;
  exp_t          m_exp;

  always @(negedge clk) begin
    if (!reset_n) begin
      m_q.delete();
      exp_q.delete();
      m_busy = '0;
      m_prev = '0;
      m_rr   = 0;
    end else begin
      chk("busy_mask", int'(busy_mask), int'(m_busy));
      chk("active_count", int'(active_count), $countones(m_busy));
      chk("mix_shift", int'(mix_shift), shift_of($countones(m_busy)));
      chk("fifo_level", int'(fifo_level), m_q.size());

      m_pop = 1'b0;
      m_tgt = 0;
      if (play && m_q.size() > 0) begin
        for (int k = 0; k < NV; k++) begin
          if (!m_pop && !m_busy[(m_rr + k) % NV]) begin
            m_pop = 1'b1;
            m_tgt = (m_rr + k) % NV;
          end
        end
`ifdef VOICE_STEAL_EN
        if (!m_pop && m_q.size() == DEPTH) begin
          m_pop = 1'b1;
          m_tgt = m_rr;
        end
`endif
      end
      m_ready = (m_q.size() < DEPTH) || m_pop;
      chk("req_ready", int'(req_ready), int'(m_ready));

      if (m_pop) begin
        m_item      = m_q.pop_front();
        m_exp.voice = m_tgt;
        m_exp.note  = m_item.note;
        m_exp.dur   = m_item.dur;
        m_exp.cyc   = cyc + 1;
        exp_q.push_back(m_exp);
        m_rr = (m_tgt + 1) % NV;
      end
      if (req_valid && m_ready) begin
        m_new.note = int'(req_note);
        m_new.dur  = int'(req_duration);
        m_q.push_back(m_new);
      end
      m_busy = m_busy & ~(voice_done & ~m_prev);
      if (m_pop) m_busy[m_tgt] = 1'b1;
      m_prev = voice_done;
    end
  end

  // -------------------------------------------------------------- monitor
  exp_t mon_e;

  always @(negedge clk) begin
    if (reset_n) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        chk("missed_load_cycle", cyc, exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
      if (load_voice != '0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_load", int'(load_voice), 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("load_voice", int'(load_voice), 1 << mon_e.voice);
          chk("load_note", int'(load_note), mon_e.note);
          chk("load_duration", int'(load_duration), mon_e.dur);
          chk("load_cycle", cyc, mon_e.cyc);
        end
      end
    end
  end

  // ------------------------------------------------------- player models
  int pcnt [NV];

  always @(posedge clk) begin
    #2;
    for (int i = 0; i < NV; i++) begin
      if (!auto_mode) begin
        auto_done[i] = 1'b0;
        pcnt[i]      = 0;
      end else if (load_voice[i]) begin
        auto_done[i] = 1'b0;
        pcnt[i]      = int'($urandom_range(2, 12));
      end else if (pcnt[i] > 0) begin
        pcnt[i] = pcnt[i] - 1;
        if (pcnt[i] == 0) auto_done[i] = 1'b1;
      end
    end
  end

  // ------------------------------------------------------------- stimulus
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    req_valid = 1'b0;
    man_done  = '0;
    play      = 1'b1;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  // Holds the request until accepted; returns #1 after the accepting edge.
  task automatic push_req(input int n, input int d, input int budget);
    bit acc;
    acc          = 1'b0;
    req_valid    = 1'b1;
    req_note     = 6'(n);
    req_duration = 6'(d);
    for (int c = 0; c < budget && !acc; c++) begin
      #3;
      acc = req_ready;
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    chk("push_accepted", int'(acc), 1);
  endtask

  initial begin
    auto_mode    = 1'b0;
    man_done     = '0;
    play         = 1'b1;
    req_valid    = 1'b0;
    req_note     = '0;
    req_duration = '0;
    reset_n      = 1'b0;
    @(posedge clk);
    #1;
    chk("reset_load_voice", int'(load_voice), 0);
    chk("reset_busy_mask", int'(busy_mask), 0);
    chk("reset_active_count", int'(active_count), 0);
    chk("reset_mix_shift", int'(mix_shift), 0);
    chk("reset_fifo_level", int'(fifo_level), 0);
    chk("reset_req_ready", int'(req_ready), 1);
    chk("reset_load_note", int'(load_note), 0);
    reset_n = 1'b1;

    // Single request to an idle bank
    do_reset();
    push_req(12, 4, 10);
    tick();
    chk("t1_load_voice", int'(load_voice), 1);
    chk("t1_load_note", int'(load_note), 12);
    chk("t1_load_duration", int'(load_duration), 4);
    chk("t1_active_count", int'(active_count), 1);
    chk("t1_mix_shift", int'(mix_shift), 0);
    repeat (2) tick();

    // Three back-to-back requests fill every voice
    do_reset();
    push_req(30, 1, 10);
    push_req(31, 2, 10);
    push_req(32, 3, 10);
    tick();
    chk("t2_active_count", int'(active_count), 3);
    chk("t2_mix_shift", int'(mix_shift), 2);
    chk("t2_busy_mask", int'(busy_mask), 7);

    // All voices busy: fill the FIFO, then free voice 1
    push_req(33, 4, 10);
    push_req(34, 5, 10);
    push_req(35, 6, 10);
    push_req(36, 7, 10);
    chk("t3_fifo_full", int'(fifo_level), 4);
`ifdef VOICE_STEAL_EN
    tick();
    chk("t3_steal_voice0", int'(load_voice), 1);
    chk("t3_steal_busy", int'(busy_mask), 7);
    chk("t3_steal_level", int'(fifo_level), 3);
`else
    chk("t3_ready_low", int'(req_ready), 0);
`endif
    fork
      push_req(37, 8, 30);
      begin
        repeat (3) tick();
        man_done[1] = 1'b1;
      end
    join
`ifndef VOICE_STEAL_EN
    chk("t3_freed_voice1", int'(load_voice), 2);
`endif
    repeat (4) tick();

    // Paused dispatch
    do_reset();
    play = 1'b0;
    push_req(7, 3, 10);
    push_req(8, 9, 10);
    repeat (2) tick();
    chk("t4_paused_level", int'(fifo_level), 2);
    chk("t4_paused_noload", int'(load_voice), 0);
    play = 1'b1;
    tick();
    chk("t4_first_load", int'(load_voice), 1);
    chk("t4_first_note", int'(load_note), 7);
    tick();
    chk("t4_second_load", int'(load_voice), 2);
    chk("t4_second_note", int'(load_note), 8);
    repeat (2) tick();

    // Reset mid-operation with requests queued
    do_reset();
    push_req(20, 1, 10);
    tick();
    play = 1'b0;
    push_req(21, 2, 10);
    push_req(22, 3, 10);
    push_req(23, 4, 10);
    push_req(24, 5, 10);
    play = 1'b1;
    tick();
    chk("t5_load_voice1", int'(load_voice), 2);
    chk("t5_level_before", int'(fifo_level), 3);
    reset_n = 1'b0;
    #1;
    chk("t5_async_load_voice", int'(load_voice), 0);
    chk("t5_async_busy_mask", int'(busy_mask), 0);
    chk("t5_async_fifo_level", int'(fifo_level), 0);
    chk("t5_async_req_ready", int'(req_ready), 1);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    tick();

    // Randomized traffic with players finishing notes after random lengths
    do_reset();
    auto_mode = 1'b1;
    for (int n = 0; n < 800; n++) begin
      req_valid    = ($urandom_range(0, 99) < 45);
      req_note     = 6'($urandom_range(0, 63));
      req_duration = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 99) < 4) play = ~play;
      tick();
    end
    req_valid = 1'b0;
    play      = 1'b1;
    for (int n = 0; n < 400 && (m_q.size() > 0 || exp_q.size() > 0); n++) tick();
    chk("drain_fifo_level", int'(fifo_level), 0);
    chk("drain_pending_loads", exp_q.size(), 0);
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/voice_allocator.md
# voice_allocator

Schedules note requests from the song reader onto a bank of `NUM_VOICES` note players, so chords are built from independent voices. It buffers requests in a small FIFO and hands each note to a free voice in round-robin order. It tracks which voices are sounding and gives the mixer the active-voice count and the matching attenuation shift. It sits between the song reader and the note players, replacing ad-hoc load steering inside the chord mixer.

## Interface
- `NUM_VOICES`, 3: number of note players driven; 2..4.
- `FIFO_DEPTH`, 4: request FIFO entries; power of two, ≥2.
- `clk` in 1: system clock; all state on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `play` in 1: 1 = dispatch enabled; 0 = dispatch paused, FIFO still accepts.
- `req_valid` in 1: request strobe from the song reader.
- `req_note` in 6: note index.
- `req_duration` in 6: duration in beats.
- `req_ready` out 1: FIFO can accept; transfer when `req_valid & req_ready`.
- `voice_done` in NUM_VOICES: `done_with_note` from each player; bit i = voice i.
- `load_voice` out NUM_VOICES: one-hot, single-cycle load strobe to a player.
- `load_note` out 6: note for the strobed voice; valid while `load_voice != 0`.
- `load_duration` out 6: duration for the strobed voice; same validity.
- `busy_mask` out NUM_VOICES: voices currently allocated.
- `active_count` out $clog2(NUM_VOICES+1): popcount of `busy_mask`.
- `mix_shift` out 2: mixer right-shift; 0 if count ≤1, 1 if count = 2, 2 if count ≥3.
- `fifo_level` out $clog2(FIFO_DEPTH+1): occupied FIFO entries.

## Operation
- Reset values:
  - all outputs 0 except `req_ready` = 1;
  - FIFO empty, `rr_ptr` = 0, `voice_done_q` = 0.
- FIFO:
  - push on accepted request; pop on dispatch;
  - simultaneous push and pop leaves the level unchanged and is legal when full;
  - `req_ready = (level < FIFO_DEPTH) | pop_this_cycle`;
  - no bypass: an empty FIFO never dispatches in the push cycle.
- Free voice: `busy_mask[i] == 0`.
- Busy tracking:
  - `busy_mask[i]` sets on the `load_voice[i]` cycle;
  - it clears on a `voice_done` rising edge (`voice_done[i] & ~voice_done_q[i]`);
  - a level-high `voice_done` alone never frees a voice, so there is no double-load while a player's done flag lags its load.
- Dispatch condition: `play & ~empty & (free mask != 0)`.
  - Selected voice: first free voice scanning `rr_ptr, rr_ptr+1, …` mod `NUM_VOICES`.
  - Registered outputs: `load_voice` one-hot, plus `load_note`/`load_duration` from the FIFO head.
  - FIFO pops; `rr_ptr` ← selected+1 mod `NUM_VOICES`.
- At most one dispatch per cycle.
- A clear edge and a load never target the same voice in one cycle, because a busy voice is never selected.
- `active_count` and `mix_shift` are registered from the next-state `busy_mask`, so they change in the same cycle as `busy_mask`.
- `play` falling: no new dispatch from the next cycle; `busy_mask` keeps tracking done edges.

## Timing
- Request accepted at edge t: earliest `load_voice` is high in cycle t+1 to t+2 (registered pop), i.e. 1 cycle after the entry becomes head.
- `load_voice` is high for exactly 1 cycle per dispatched note.
- A `voice_done` rising edge sampled at edge t frees the voice for a dispatch decision in cycle t+1.
- Back-to-back dispatch to different free voices: one note per cycle.
- Reset assertion mid-operation: outputs clear immediately (asynchronous); queued requests are discarded.

## Configuration
- `VOICE_STEAL_EN` defined:
  - when the FIFO is full, `play` = 1 and no voice is free, the block steals voice `rr_ptr`;
  - `load_voice[rr_ptr]` pulses with the head entry, the FIFO pops, `rr_ptr` advances, and `busy_mask` stays set;
  - a steal occurs at most once per cycle.
- `VOICE_STEAL_EN` undefined: with no free voice the block waits; `req_ready` drops when the FIFO is full.

## Test plan
- Reset, then push one request (note 12, duration 4) with all voices idle → `load_voice` = 001 in the cycle after the push, `load_note` = 12, `load_duration` = 4, `active_count` = 1, `mix_shift` = 0.
- Push three requests back-to-back → loads to voices 0, 1, 2 in consecutive cycles; `active_count` = 3, `mix_shift` = 2.
- All voices busy, push 5 requests with steal undefined → `fifo_level` reaches 4; `req_ready` = 0; the 5th request is held until voice 1 `voice_done` rises; that voice is loaded the next cycle.
- Same stimulus with `VOICE_STEAL_EN` defined → on FIFO full, voice `rr_ptr` (0) is reloaded; `rr_ptr` → 1; `busy_mask` stays 111.
- `play` = 0 with 2 queued requests → no `load_voice`; after `play` = 1, two loads on consecutive cycles.
- Assert `reset_n` low while `load_voice` = 010 with 3 queued requests → `load_voice`, `busy_mask` and `fifo_level` are 0 in the same cycle; `req_ready` = 1.
